// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared fp32 field layout, constants and FSM state encoding
package fp32_pkg;
  localparam int SIGN_BIT   = 31;
  localparam int EXP_MSB    = 30;
  localparam int EXP_LSB    = 23;
  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;
  localparam int MAG_W      = MANT_W + 1;
  localparam int EXP_BIAS   = 127;
  localparam int MAX_RSHIFT = 25;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_SIGN   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_UNPACK = S_UNPACK,
    ST_SHIFT  = S_SHIFT,
    ST_ROUND  = S_ROUND,
    ST_SIGN   = S_SIGN,
    ST_DONE   = S_DONE
  } state_t;
endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - classify an fp32 operand and derive shift direction/count
module fp32_unpack
  import fp32_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic [31:0]      x,
  output logic             is_zero,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_ovf,
  output logic             is_min,
  output logic             shl,
  output logic [4:0]       n,
  output logic [MAG_W-1:0] mag
);
  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant;
  logic signed [9:0] e_unb;
  logic signed [9:0] sh;
  logic signed [9:0] neg_sh;

  assign exp_f  = x[EXP_MSB:EXP_LSB];
  assign mant   = x[MANT_W-1:0];
  // e_unb is the bit position of the hidden one in the fixed-point result
  assign e_unb  = signed'(10'(exp_f) + 10'(FRAC_BITS) - 10'(EXP_BIAS));
  assign sh     = e_unb - signed'(10'(MANT_W));
  assign neg_sh = -sh;

  assign is_zero = (exp_f == '0);
  assign is_nan  = (exp_f == EXP_MAX) && (mant != '0);
  assign is_inf  = (exp_f == EXP_MAX) && (mant == '0);
  assign is_ovf  = (e_unb >= 10'sd31);
  assign is_min  = x[SIGN_BIT] && (e_unb == 10'sd31) && (mant == '0);
  assign shl     = !sh[9];
  assign mag     = {1'b1, mant};

  // Right shifts past the hidden bit plus one all round to zero
  assign n = sh[9] ? ((neg_sh > signed'(10'(MAX_RSHIFT))) ? 5'(MAX_RSHIFT) : neg_sh[4:0])
                   : sh[4:0];
endmodule

// File: rtl/fp32_to_fix_fsm.sv
// rtl/fp32_to_fix_fsm.sv - multi-cycle fp32 to signed fixed-point converter (RNE, saturating)
module fp32_to_fix_fsm
  import fp32_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        err_i,
  input  logic        r_i,
  output logic [31:0] res,
  output logic        err,
  output logic        r_o
);
  state_t      state;
  logic [31:0] x_q;
  logic        err_i_q;
  logic [31:0] mag;
  logic        guard;
  logic        sticky;
  logic [4:0]  cnt;
  logic        left;
  logic        err_acc;
  logic        pend;

  logic             u_zero, u_nan, u_inf, u_ovf, u_min, u_shl;
  logic [4:0]       u_n;
  logic [MAG_W-1:0] u_mag;

  fp32_unpack #(.FRAC_BITS(FRAC_BITS)) u_unpack (
    .x       (x_q),
    .is_zero (u_zero),
    .is_nan  (u_nan),
    .is_inf  (u_inf),
    .is_ovf  (u_ovf),
    .is_min  (u_min),
    .shl     (u_shl),
    .n       (u_n),
    .mag     (u_mag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      x_q     <= '0;
      err_i_q <= 1'b0;
      mag     <= '0;
      guard   <= 1'b0;
      sticky  <= 1'b0;
      cnt     <= '0;
      left    <= 1'b0;
      err_acc <= 1'b0;
      pend    <= 1'b0;
      res     <= '0;
      err     <= 1'b0;
      r_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          r_o <= 1'b0;
          if (r_i) begin
            x_q     <= x;
            err_i_q <= err_i;
            state   <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          guard   <= 1'b0;
          sticky  <= 1'b0;
          err_acc <= err_i_q;
          cnt     <= u_n;
          left    <= u_shl;
          // Special cases park their final value in mag and finish through DONE
          if (u_nan) begin
            mag <= SAT_POS; err_acc <= 1'b1; pend <= 1'b1; state <= ST_DONE;
          end else if (u_inf || (u_ovf && !u_min)) begin
            mag <= x_q[SIGN_BIT] ? SAT_NEG : SAT_POS;
            err_acc <= 1'b1; pend <= 1'b1; state <= ST_DONE;
          end else if (u_min) begin
            mag <= SAT_NEG; pend <= 1'b1; state <= ST_DONE;
          end else if (u_zero) begin
            mag <= '0; pend <= 1'b1; state <= ST_DONE;
          end else begin
            mag   <= {8'b0, u_mag};
            state <= (u_n == '0) ? ST_ROUND : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (left) begin
            mag <= {mag[30:0], 1'b0};
          end else begin
            sticky <= sticky | guard;
            guard  <= mag[0];
            mag    <= {1'b0, mag[31:1]};
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (guard && (sticky || mag[0])) mag <= mag + 32'd1;
          state <= ST_SIGN;
        end
        ST_SIGN: begin
          res   <= x_q[SIGN_BIT] ? (~mag + 32'd1) : mag;
          err   <= err_acc;
          r_o   <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (pend) begin
            res  <= mag;
            err  <= err_acc;
            r_o  <= 1'b1;
            pend <= 1'b0;
          end else begin
            r_o   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
